// File: rtl/stack_controller.sv
// LIFO controller for a 1024x8 async RAM: push takes 3 busy cycles after acceptance, pop takes 2.
// Requests are sampled only in IDLE. Push/Pop seen while Busy are dropped, with no queueing and no flag.
module stack_controller #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Push,
  input  logic              Pop,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              Valid,
  output logic              Busy,
  output logic              Full,
  output logic              Empty,
  output logic [ADDR_W:0]   Count,
  output logic              Ovf,
  output logic              Unf,
  output logic [ADDR_W-1:0] Address,
  output logic              RWS,
  output logic              CS,
  inout  wire  [DATA_W-1:0] IO
);

  typedef enum logic [2:0] {
    IDLE, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_READ
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   dout_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [ADDR_W:0]     count_d, count_m1;
  logic                rws_d, cs_d, valid_d, ovf_d, unf_d, busy_d;
  logic                drive_io;

  assign Full     = (Count == DEPTH_C);
  assign Empty    = (Count == '0);
  assign count_m1 = Count - 1'b1;

  // Decoded from the async-reset state register so reset releases the bus at once.
  assign drive_io = (state_q == W_SETUP) || (state_q == W_STROBE) || (state_q == W_HOLD);
  assign IO       = drive_io ? wdata_q : {DATA_W{1'bz}};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (Push && !Full)                state_d = W_SETUP;
        else if (!Push && Pop && !Empty)  state_d = R_SETUP;
      end
      W_SETUP:  state_d = W_STROBE;
      W_STROBE: state_d = W_HOLD;
      W_HOLD:   state_d = IDLE;
      R_SETUP:  state_d = R_READ;
      R_READ:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    wdata_d = wdata_q;
    dout_d  = DataOut;
    addr_d  = Address;
    count_d = Count;
    rws_d   = RWS;
    cs_d    = CS;
    valid_d = 1'b0;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    busy_d  = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        // Push has priority; a Pop arriving alongside it is silently dropped.
        if (Push) begin
          if (!Full) begin
            wdata_d = DataIn;
            addr_d  = Count[ADDR_W-1:0];
            rws_d   = 1'b1;
            cs_d    = 1'b0;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (Pop) begin
          if (!Empty) begin
            addr_d = count_m1[ADDR_W-1:0];
            rws_d  = 1'b0;
            cs_d   = 1'b0;
          end else begin
            unf_d = 1'b1;
          end
        end
      end
      W_SETUP:  cs_d = 1'b1;
      W_STROBE: cs_d = 1'b0;
      W_HOLD: begin
        count_d = Count + 1'b1;
        rws_d   = 1'b0;
      end
      R_SETUP:  cs_d = 1'b1;
      R_READ: begin
        dout_d  = IO;
        count_d = count_m1;
        cs_d    = 1'b0;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wdata_q <= '0;
      DataOut <= '0;
      Address <= '0;
      Count   <= '0;
      RWS     <= 1'b0;
      CS      <= 1'b0;
      Valid   <= 1'b0;
      Ovf     <= 1'b0;
      Unf     <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      wdata_q <= wdata_d;
      DataOut <= dout_d;
      Address <= addr_d;
      Count   <= count_d;
      RWS     <= rws_d;
      CS      <= cs_d;
      Valid   <= valid_d;
      Ovf     <= ovf_d;
      Unf     <= unf_d;
      Busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_stack_controller.sv
// Directed bench for stack_controller with a behavioural 1024x8 async RAM on the IO bus.
module tb_stack_controller;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       Push, Pop;
  logic [7:0] DataIn;
  logic [7:0] DataOut;
  logic       Valid, Busy, Full, Empty, Ovf, Unf, RWS, CS;
  logic [10:0] Count;
  logic [9:0] Address;
  wire  [7:0] IO;

  logic [7:0] mem [0:1023];
  int checks   = 0;
  int failures = 0;
  logic [9:0] pa;

  stack_controller #(.ADDR_W(10), .DATA_W(8), .DEPTH(1024)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Push(Push), .Pop(Pop), .DataIn(DataIn),
    .DataOut(DataOut), .Valid(Valid), .Busy(Busy), .Full(Full), .Empty(Empty),
    .Count(Count), .Ovf(Ovf), .Unf(Unf), .Address(Address), .RWS(RWS),
    .CS(CS), .IO(IO)
  );

  always #5 Clk = ~Clk;

  // RAM: drives the bus during read strobes, latches the bus while a write strobe is active.
  assign IO = (CS && !RWS) ? mem[Address] : 8'hzz;
  always @(posedge Clk) if (CS && RWS) mem[Address] <= IO;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_op(input logic [7:0] d);
    Push = 1'b1; DataIn = d; step();
    Push = 1'b0; step(); step(); step();
  endtask

  task automatic pop_op(output logic [9:0] addr);
    Pop = 1'b1; step();
    addr = Address;
    Pop = 1'b0; step(); step();
  endtask

  initial begin
    Rst_n = 1'b0; Push = 1'b0; Pop = 1'b0; DataIn = 8'h00;
    #12;
    check("rst_count", Count, 0);
    check("rst_empty", Empty, 1);
    check("rst_full", Full, 0);
    check("rst_cs", CS, 0);
    check("rst_rws", RWS, 0);
    check("rst_addr", Address, 0);
    check("rst_dout", DataOut, 0);
    check("rst_valid", Valid, 0);
    check("rst_busy", Busy, 0);
    check("rst_io_z", IO === 8'hzz, 1);
    Rst_n = 1'b1;
    step();

    // Reset asserted in the middle of a write strobe.
    Push = 1'b1; DataIn = 8'h99; step();
    Push = 1'b0; step();
    check("wstrobe_cs", CS, 1);
    #3 Rst_n = 1'b0;
    #1;
    check("midrst_cs", CS, 0);
    check("midrst_io_z", IO === 8'hzz, 1);
    check("midrst_busy", Busy, 0);
    #2 Rst_n = 1'b1;
    step();
    check("postrst_count", Count, 0);
    check("postrst_empty", Empty, 1);

    // Push timing and bus discipline.
    Push = 1'b1; DataIn = 8'h11; step();
    Push = 1'b0;
    check("ws_busy", Busy, 1);
    check("ws_cs", CS, 0);
    check("ws_rws", RWS, 1);
    check("ws_addr", Address, 0);
    check("ws_io", IO, 8'h11);
    step();
    check("wt_cs", CS, 1);
    check("wt_rws", RWS, 1);
    check("wt_addr", Address, 0);
    check("wt_io", IO, 8'h11);
    step();
    check("wh_cs", CS, 0);
    check("wh_io", IO, 8'h11);
    check("wh_busy", Busy, 1);
    check("wh_count", Count, 0);
    step();
    check("wi_busy", Busy, 0);
    check("wi_count", Count, 1);
    check("wi_rws", RWS, 0);
    check("wi_io_z", IO === 8'hzz, 1);

    // Pop timing: controller must leave IO to the RAM.
    Pop = 1'b1; step();
    Pop = 1'b0;
    check("rs_cs", CS, 0);
    check("rs_rws", RWS, 0);
    check("rs_addr", Address, 0);
    check("rs_io_z", IO === 8'hzz, 1);
    check("rs_busy", Busy, 1);
    step();
    check("rr_cs", CS, 1);
    check("rr_rws", RWS, 0);
    check("rr_io", IO, 8'h11);
    check("rr_valid", Valid, 0);
    step();
    check("ri_valid", Valid, 1);
    check("ri_dout", DataOut, 8'h11);
    check("ri_count", Count, 0);
    check("ri_cs", CS, 0);
    step();
    check("ri_valid_1cyc", Valid, 0);

    // LIFO ordering.
    push_op(8'hA5); push_op(8'h3C); push_op(8'h7E);
    check("ord_count3", Count, 3);
    pop_op(pa);
    check("ord_addr0", pa, 2);
    check("ord_dout0", DataOut, 8'h7E);
    check("ord_valid0", Valid, 1);
    step();
    check("ord_valid0_1cyc", Valid, 0);
    pop_op(pa);
    check("ord_addr1", pa, 1);
    check("ord_dout1", DataOut, 8'h3C);
    check("ord_valid1", Valid, 1);
    pop_op(pa);
    check("ord_addr2", pa, 0);
    check("ord_dout2", DataOut, 8'hA5);
    check("ord_count0", Count, 0);
    step();

    // Underflow.
    Pop = 1'b1; step();
    Pop = 1'b0;
    check("unf_pulse", Unf, 1);
    check("unf_valid", Valid, 0);
    check("unf_busy", Busy, 0);
    step();
    check("unf_1cyc", Unf, 0);
    check("unf_count", Count, 0);

    // Simultaneous Push+Pop: push wins.
    Push = 1'b1; Pop = 1'b1; DataIn = 8'h5A; step();
    Push = 1'b0; Pop = 1'b0;
    check("sim_rws", RWS, 1);
    check("sim_busy", Busy, 1);
    step(); step(); step();
    check("sim_count", Count, 1);
    check("sim_valid", Valid, 0);

    // Pop during W_STROBE is ignored.
    Push = 1'b1; DataIn = 8'h22; step();
    Push = 1'b0; step();
    Pop = 1'b1; step();
    Pop = 1'b0; step();
    check("busy_pop_count", Count, 2);
    step();
    check("busy_pop_idle", Busy, 0);
    check("busy_pop_count2", Count, 2);
    pop_op(pa);
    check("busy_pop_d0", DataOut, 8'h22);
    pop_op(pa);
    check("busy_pop_d1", DataOut, 8'h5A);
    check("busy_pop_empty", Empty, 1);

    // Fill to capacity, overflow, then pop the top.
    for (int i = 0; i < 1024; i++) push_op(8'(i));
    check("full_flag", Full, 1);
    check("full_count", Count, 1024);
    check("full_empty", Empty, 0);
    Push = 1'b1; DataIn = 8'hEE; step();
    Push = 1'b0;
    check("ovf_pulse", Ovf, 1);
    check("ovf_busy", Busy, 0);
    step();
    check("ovf_1cyc", Ovf, 0);
    check("ovf_count", Count, 1024);
    pop_op(pa);
    check("full_pop_addr", pa, 1023);
    check("full_pop_dout", DataOut, 8'hFF);
    check("full_pop_count", Count, 1023);
    check("full_pop_full", Full, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
